// File: rtl/rv_test_sequencer_if.sv
// rtl/rv_test_sequencer_if.sv - program-load stream, imem write port and register debug port of the test sequencer
interface rv_test_sequencer_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 6
);
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;
  logic              imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [4:0]        rf_raddr;
  logic [XLEN-1:0]   rf_rdata;

  modport master (
    input  load_valid, load_data, load_last, rf_rdata,
    output load_ready, imem_we, imem_waddr, imem_wdata, rf_raddr
  );

  modport slave (
    output load_valid, load_data, load_last, rf_rdata,
    input  load_ready, imem_we, imem_waddr, imem_wdata, rf_raddr
  );
endinterface

// File: rtl/rv_test_sequencer.sv
// rtl/rv_test_sequencer.sv - load/reset/run/check self-test controller for the RV32 core
// Optional early exit on branch-to-self halt: define RV_SEQ_HALT_DETECT_EN.
module rv_test_sequencer #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter int NUM_CHECKS = 4,
  parameter int CYCLE_W    = 16,
  parameter int RST_HOLD   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  rv_test_sequencer_if.master     bus,
  input  logic                    start,
  input  logic [CYCLE_W-1:0]      run_cycles,
  output logic                    core_n_rst,
  input  logic                    cfg_we,
  input  logic [(NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1)-1:0] cfg_idx,
  input  logic                    cfg_en,
  input  logic [4:0]              cfg_reg,
  input  logic [XLEN-1:0]         cfg_expect,
  input  logic [XLEN-1:0]         pc,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [NUM_CHECKS-1:0]   fail_mask,
  output logic                    overflow,
  output logic [CYCLE_W-1:0]      cycle_count
);
  localparam int IDX_W  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CHECKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_CHECK, S_DONE} state_t;
  state_t state, next;

  logic [CYCLE_W-1:0]  budget;
  logic [IMEM_AW:0]    wptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    chk_idx;
  logic                slot_en  [NUM_CHECKS];
  logic [4:0]          slot_reg [NUM_CHECKS];
  logic [XLEN-1:0]     slot_exp [NUM_CHECKS];
  logic                halt_hit;
  logic                run_end;
  logic                launch;

  // wptr stops at IMEM_DEPTH, so its top bit doubles as the "memory full" flag
  assign launch  = start && (state == S_IDLE || state == S_DONE);
  assign run_end = (cycle_count == budget - CYCLE_W'(1)) || halt_hit;

`ifdef RV_SEQ_HALT_DETECT_EN
  logic [XLEN-1:0] pc_prev;
  logic [1:0]      same_cnt;
  logic            pc_same;

  // cycle_count==0 marks the first RUN cycle, where pc_prev is stale
  assign pc_same  = (cycle_count != '0) && (pc == pc_prev);
  assign halt_hit = (state == S_RUN) && pc_same && (same_cnt == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_prev  <= '0;
      same_cnt <= '0;
    end else if (state == S_RUN) begin
      pc_prev  <= pc;
      same_cnt <= pc_same ? same_cnt + 2'd1 : 2'd0;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign halt_hit  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE: if (start) next = S_LOAD;
      S_LOAD:  if (bus.load_valid && bus.load_last) next = S_HOLD;
      S_HOLD:  if (hold_cnt == HOLD_LAST) next = (budget == '0) ? S_CHECK : S_RUN;
      S_RUN:   if (run_end) next = S_CHECK;
      S_CHECK: if (chk_idx == IDX_LAST) next = S_DONE;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state == S_LOAD);
    bus.imem_we    = (state == S_LOAD) && bus.load_valid && !wptr[IMEM_AW];
    bus.imem_waddr = wptr[IMEM_AW-1:0];
    bus.imem_wdata = (state == S_LOAD) ? bus.load_data : 32'd0;
    bus.rf_raddr   = (state == S_CHECK) ? slot_reg[chk_idx] : 5'd0;
    core_n_rst     = (state == S_RUN);
    busy           = (state != S_IDLE) && (state != S_DONE);
    done           = (state == S_DONE);
    pass           = (state == S_DONE) && (fail_mask == '0) && !overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      budget      <= '0;
      wptr        <= '0;
      hold_cnt    <= '0;
      chk_idx     <= '0;
      fail_mask   <= '0;
      overflow    <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (launch) begin
          budget      <= run_cycles;
          wptr        <= '0;
          hold_cnt    <= '0;
          chk_idx     <= '0;
          fail_mask   <= '0;
          overflow    <= 1'b0;
          cycle_count <= '0;
        end
        S_LOAD: if (bus.load_valid) begin
          if (wptr[IMEM_AW]) overflow <= 1'b1;
          else               wptr     <= wptr + 1'b1;
        end
        S_HOLD: hold_cnt <= hold_cnt + 1'b1;
        S_RUN:  if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        S_CHECK: begin
          if (slot_en[chk_idx] && (bus.rf_rdata != slot_exp[chk_idx]))
            fail_mask[chk_idx] <= 1'b1;
          chk_idx <= (chk_idx == IDX_LAST) ? '0 : chk_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        slot_en[i]  <= 1'b0;
        slot_reg[i] <= '0;
        slot_exp[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      slot_en[cfg_idx]  <= cfg_en;
      slot_reg[cfg_idx] <= cfg_reg;
      slot_exp[cfg_idx] <= cfg_expect;
    end
  end
endmodule
